// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding, lamp patterns and default timings for the intersection scheduler
package traffic_pkg;

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5
    } phase_t;

    localparam int unsigned SHORT_DEF = 5;
    localparam int unsigned LONG_DEF  = 20;

    // Lamp vectors are ordered {HR, HY, HG, FR, FY, FG}; one lamp per road is lit.
    localparam logic [5:0] LAMP_HG = 6'b001_100;
    localparam logic [5:0] LAMP_HY = 6'b010_100;
    localparam logic [5:0] LAMP_AR = 6'b100_100;
    localparam logic [5:0] LAMP_FG = 6'b100_001;
    localparam logic [5:0] LAMP_FY = 6'b100_010;

    function automatic logic [5:0] lamp_decode(input phase_t p);
        case (p)
            S_HG:    return LAMP_HG;
            S_HY:    return LAMP_HY;
            S_FG:    return LAMP_FG;
            S_FY:    return LAMP_FY;
            default: return LAMP_AR;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - shared phase timer with synchronous clear and saturating increment
module phase_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - highway/farm-road phase FSM with pedestrian latch and boundary-applied timing config
module traffic_phase_scheduler #(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned SHORT_DEF  = traffic_pkg::SHORT_DEF,
    parameter int unsigned LONG_DEF   = traffic_pkg::LONG_DEF,
    parameter int unsigned ALLRED_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_i,
    input  logic             ped_req_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_short_i,
    input  logic [CNT_W-1:0] cfg_long_i,
    output logic             HR,
    output logic             HY,
    output logic             HG,
    output logic             FR,
    output logic             FY,
    output logic             FG,
    output logic             ped_walk_o,
    output logic [2:0]       phase_o
);

    import traffic_pkg::*;

    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYC - 1);

    phase_t           state;
    phase_t           state_next;
    logic [CNT_W-1:0] t;
    logic [5:0]       lamps;
    logic [CNT_W-1:0] short_act;
    logic [CNT_W-1:0] long_act;
    logic [CNT_W-1:0] short_pend;
    logic [CNT_W-1:0] long_pend;
    logic [CNT_W-1:0] short_m1;
    logic [CNT_W-1:0] long_m1;
    logic [CNT_W-1:0] short_fix;
    logic [CNT_W-1:0] long_fix;
    logic             ped_pend;
    logic             ped_hold;
    logic             enter_fg;
    logic             exit_fg;
    logic             apply_cfg;
    logic             take_cfg;
    logic             timer_clr;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .clr (timer_clr),
        .en  (1'b1),
        .cnt (t)
    );

    assign timer_clr = rst || (state_next != state);
    assign short_m1  = short_act - 1'b1;
    assign long_m1   = long_act - 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            S_HG:    if ((t >= long_m1) && (car_i || ped_pend)) state_next = S_HY;
            S_HY:    if (t == short_m1) state_next = S_AR1;
            S_AR1:   if (t == AR_LAST) state_next = S_FG;
            S_FG:    if ((t == long_m1) || (!car_i && !ped_walk_o && (t >= short_m1)))
                         state_next = S_FY;
            S_FY:    if (t == short_m1) state_next = S_AR2;
            S_AR2:   if (t == AR_LAST) state_next = S_HG;
            default: state_next = S_HG;
        endcase
    end

    always_comb begin
        enter_fg  = (state == S_AR1) && (state_next == S_FG);
        exit_fg   = (state == S_FG) && (state_next != S_FG);
        apply_cfg = (state == S_AR2) && (state_next == S_HG) && !cfg_ready_o;
        take_cfg  = cfg_valid_i && cfg_ready_o;
        short_fix = (cfg_short_i == '0) ? CNT_W'(1) : cfg_short_i;
        long_fix  = (cfg_long_i == '0) ? CNT_W'(1) : cfg_long_i;
        if (long_fix < short_fix) long_fix = short_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HG;
            lamps       <= LAMP_HG;
            ped_walk_o  <= 1'b0;
            ped_pend    <= 1'b0;
            ped_hold    <= 1'b0;
            cfg_ready_o <= 1'b1;
            short_act   <= CNT_W'(SHORT_DEF);
            long_act    <= CNT_W'(LONG_DEF);
            short_pend  <= '0;
            long_pend   <= '0;
        end else begin
            state <= state_next;
            lamps <= lamp_decode(state_next);

            if (enter_fg) begin
                ped_walk_o <= ped_pend;
            end else if (exit_fg) begin
                ped_walk_o <= 1'b0;
            end

            // Requests made during farm green wait in ped_hold and re-arm ped_pend on exit.
            if (enter_fg) begin
                ped_pend <= ped_req_i;
            end else if (exit_fg) begin
                ped_pend <= ped_hold || ped_req_i;
            end else if ((state != S_FG) && ped_req_i) begin
                ped_pend <= 1'b1;
            end

            if (state == S_FG) begin
                ped_hold <= (ped_hold || ped_req_i) && !exit_fg;
            end else begin
                ped_hold <= 1'b0;
            end

            if (apply_cfg) begin
                short_act   <= short_pend;
                long_act    <= long_pend;
                cfg_ready_o <= 1'b1;
            end else if (take_cfg) begin
                short_pend  <= short_fix;
                long_pend   <= long_fix;
                cfg_ready_o <= 1'b0;
            end
        end
    end

    assign {HR, HY, HG, FR, FY, FG} = lamps;
    assign phase_o = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

    localparam int P_HG = 0, P_HY = 1, P_AR1 = 2, P_FG = 3, P_FY = 4, P_AR2 = 5;
    localparam int L_HG = 6'b001100;
    localparam int L_HY = 6'b010100;
    localparam int L_AR = 6'b100100;
    localparam int L_FG = 6'b100001;
    localparam int L_FY = 6'b100010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_i = 1'b0;
    logic       ped_req_i = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [5:0] cfg_short_i = '0;
    logic [5:0] cfg_long_i = '0;
    logic       HR, HY, HG, FR, FY, FG;
    logic       ped_walk_o;
    logic [2:0] phase_o;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .car_i       (car_i),
        .ped_req_i   (ped_req_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_short_i (cfg_short_i),
        .cfg_long_i  (cfg_long_i),
        .HR          (HR),
        .HY          (HY),
        .HG          (HG),
        .FR          (FR),
        .FY          (FY),
        .FG          (FG),
        .ped_walk_o  (ped_walk_o),
        .phase_o     (phase_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_phase(input string tag, input int exp_phase, input int exp_lamps);
        chk({tag, ".phase"}, int'(phase_o), exp_phase);
        chk({tag, ".lamps"}, int'({HR, HY, HG, FR, FY, FG}), exp_lamps);
    endtask

    task automatic do_reset(input logic car);
        rst = 1'b1;
        car_i = car;
        ped_req_i = 1'b0;
        cfg_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // 1: idle highway green holds, timer saturates
        do_reset(1'b0);
        chk_phase("rst", P_HG, L_HG);
        chk("rst.walk", int'(ped_walk_o), 0);
        chk("rst.ready", int'(cfg_ready_o), 1);
        goto(100);
        chk_phase("idle100", P_HG, L_HG);
        chk("idle100.t", int'(dut.t), 63);
        car_i = 1'b1;
        goto(101);
        chk_phase("idle.car", P_HY, L_HY);

        // 2: default timings with a waiting car
        do_reset(1'b1);
        goto(19);
        chk_phase("t2.c19", P_HG, L_HG);
        goto(20);
        chk_phase("t2.c20", P_HY, L_HY);
        goto(24);
        chk_phase("t2.c24", P_HY, L_HY);
        goto(25);
        chk_phase("t2.c25", P_AR1, L_AR);
        goto(27);
        chk_phase("t2.c27", P_FG, L_FG);
        chk("t2.walk", int'(ped_walk_o), 0);
        goto(46);
        chk_phase("t2.c46", P_FG, L_FG);
        goto(47);
        chk_phase("t2.c47", P_FY, L_FY);
        goto(52);
        chk_phase("t2.c52", P_AR2, L_AR);
        goto(54);
        chk_phase("t2.c54", P_HG, L_HG);

        // 3: car leaves early in farm green, short minimum still honoured
        do_reset(1'b1);
        goto(30);
        car_i = 1'b0;
        goto(31);
        chk_phase("t3.c31", P_FG, L_FG);
        goto(32);
        chk_phase("t3.c32", P_FY, L_FY);

        // 4: pedestrian request, walk for full farm green, request in FG re-arms
        do_reset(1'b0);
        goto(3);
        ped_req_i = 1'b1;
        goto(4);
        ped_req_i = 1'b0;
        goto(20);
        chk_phase("t4.c20", P_HY, L_HY);
        goto(26);
        chk("t4.c26.walk", int'(ped_walk_o), 0);
        goto(27);
        chk_phase("t4.c27", P_FG, L_FG);
        chk("t4.c27.walk", int'(ped_walk_o), 1);
        goto(30);
        ped_req_i = 1'b1;
        goto(31);
        ped_req_i = 1'b0;
        goto(46);
        chk_phase("t4.c46", P_FG, L_FG);
        chk("t4.c46.walk", int'(ped_walk_o), 1);
        goto(47);
        chk_phase("t4.c47", P_FY, L_FY);
        chk("t4.c47.walk", int'(ped_walk_o), 0);
        goto(73);
        chk_phase("t4.c73", P_HG, L_HG);
        goto(74);
        chk_phase("t4.c74", P_HY, L_HY);
        goto(81);
        chk_phase("t4.c81", P_FG, L_FG);
        chk("t4.c81.walk", int'(ped_walk_o), 1);

        // 5: new timing applied only at the AR2 -> HG boundary
        do_reset(1'b1);
        goto(2);
        chk("t5.c2.ready", int'(cfg_ready_o), 1);
        cfg_valid_i = 1'b1;
        cfg_short_i = 6'd2;
        cfg_long_i = 6'd8;
        goto(3);
        cfg_valid_i = 1'b0;
        chk("t5.c3.ready", int'(cfg_ready_o), 0);
        goto(20);
        chk_phase("t5.c20", P_HY, L_HY);
        goto(53);
        chk_phase("t5.c53", P_AR2, L_AR);
        chk("t5.c53.ready", int'(cfg_ready_o), 0);
        goto(54);
        chk_phase("t5.c54", P_HG, L_HG);
        chk("t5.c54.ready", int'(cfg_ready_o), 1);
        goto(61);
        chk_phase("t5.c61", P_HG, L_HG);
        goto(62);
        chk_phase("t5.c62", P_HY, L_HY);
        goto(63);
        chk_phase("t5.c63", P_HY, L_HY);
        goto(64);
        chk_phase("t5.c64", P_AR1, L_AR);

        // 6: zero fields become 1-cycle phases, then reset mid-yellow
        do_reset(1'b1);
        cfg_valid_i = 1'b1;
        cfg_short_i = 6'd0;
        cfg_long_i = 6'd0;
        goto(1);
        cfg_valid_i = 1'b0;
        goto(54);
        chk_phase("t6.c54", P_HG, L_HG);
        goto(55);
        chk_phase("t6.c55", P_HY, L_HY);
        goto(56);
        chk_phase("t6.c56", P_AR1, L_AR);
        goto(58);
        chk_phase("t6.c58", P_FG, L_FG);
        goto(59);
        chk_phase("t6.c59", P_FY, L_FY);
        rst = 1'b1;
        goto(60);
        rst = 1'b0;
        chk_phase("t6.rst", P_HG, L_HG);
        chk("t6.rst.walk", int'(ped_walk_o), 0);
        chk("t6.rst.ready", int'(cfg_ready_o), 1);
        goto(66);
        chk_phase("t6.c66", P_HG, L_HG);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
